axis_rr_frame_arb: RTL and testbench
====================================

// Module: axis_rr_frame_arb
// PURPOSE
//  Frame-aware round-robin arbiter that shares one AXI4-Stream sink between S_COUNT source streams.
//  Sits in front of the team's AXI-Stream FIFO and sequences access to it.
//  A grant is held from the first beat of a frame until its tlast beat, so frames never interleave.
//  The source index is tagged on m_axis_tid, and the output is registered.
// PARAMETERS
//  S_COUNT     4  number of source ports (>=1)
//  DATA_WIDTH  8  tdata width per port
//  USER_WIDTH  1  tuser width per port
//  SEL_WIDTH   $clog2(S_COUNT) (min 1), localparam  width of grant index / tid
// PORTS
//  clk              in   1                     clock; all logic on rising edge
//  rst              in   1                     synchronous, active-high reset
//  s_axis_tdata     in   S_COUNT*DATA_WIDTH    port i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_tvalid    in   S_COUNT               per-port valid
//  s_axis_tready    out  S_COUNT               per-port ready (at most one bit set)
//  s_axis_tlast     in   S_COUNT               per-port end of frame
//  s_axis_tuser     in   S_COUNT*USER_WIDTH    per-port user sideband
//  m_axis_tdata     out  DATA_WIDTH            granted data, registered
//  m_axis_tvalid    out  1                     output valid, registered
//  m_axis_tready    in   1                     downstream ready (e.g. FIFO s_axis_tready)
//  m_axis_tlast     out  1                     registered tlast
//  m_axis_tuser     out  USER_WIDTH            registered tuser
//  m_axis_tid       out  SEL_WIDTH             index of the source port that produced the beat
//  grant_valid      out  1                     high while state==ACTIVE
//  grant_index      out  SEL_WIDTH             current/last granted port
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant_index=0, grant_valid=0, m_axis_tvalid=0, s_axis_tready=0.
//  m_axis data, tlast, tuser and tid are don't-care while m_axis_tvalid=0.
//  Output stage: out_ready = m_axis_tready | ~m_axis_tvalid.
//  Beat accept into the output stage: tvalid & tready on the granted port; the beat loads the output
//   register, with m_axis_tid = grant_index.
//  If out_ready and no beat is accepted, m_axis_tvalid clears to 0.
//  If ~out_ready, the output register holds its contents.
//  FSM:
//   IDLE: s_axis_tready=0. When any s_axis_tvalid is set, select the first valid port scanning
//    rr_ptr, rr_ptr+1, ... (mod S_COUNT); grant_index<=that port; go to ACTIVE. Otherwise stay in IDLE.
//   ACTIVE: s_axis_tready[grant_index] = out_ready; all other ready bits are 0.
//    On an accepted beat with tlast=1: go to IDLE and set rr_ptr <= (grant_index+1) mod S_COUNT.
//  Latency: a request seen in IDLE at cycle N gives ready at N+1 (if out_ready).
//   The beat accepted at N+1 appears on m_axis at N+2.
//  There is one IDLE bubble cycle between consecutive frames (no same-cycle re-arbitration).
//  Single-beat frame (tlast on the first beat): ACTIVE lasts exactly one accepted beat.
//  Granted source drops tvalid mid-frame: the grant is held; there is no timeout and no switch.
//  Non-granted sources are never given ready, regardless of their tvalid or tlast.
//  Downstream stall (m_axis_tready=0 with m_axis_tvalid=1): the output holds,
//   and ready to the granted port is 0.
//  rr_ptr wraps from S_COUNT-1 to 0; S_COUNT=1 degenerates to a pass-through with an IDLE gap per frame.
//  Reset mid-frame: the partial frame is abandoned, any pending output beat is discarded
//   (tvalid=0 next cycle), and the next grant starts from port 0.
// TESTING
//  1. All 4 ports valid at once, each sending 3-beat frames -> frames emerge in order
//     tid 0,1,2,3,0, each a contiguous 3 beats, with 1 idle cycle between frames.
//  2. Port 2 valid in IDLE at cycle 10 with single beat 0xA5, tlast=1 ->
//     s_axis_tready[2]=1 at cycle 11; m_axis tdata=0xA5, tid=2, tlast=1 at cycle 12; grant_valid=0 at 12.
//  3. Port 1 granted, drops tvalid for 5 cycles mid-frame while port 3 is valid ->
//     s_axis_tready[3] stays 0 and port 1's frame completes before port 3 is granted.
//  4. m_axis_tready=0 for 4 cycles mid-frame ->
//     m_axis output stable, granted ready=0, no beats lost or duplicated (scoreboard count matches).
//  5. rst asserted on the 2nd beat of a 4-beat frame from port 3 ->
//     next cycle m_axis_tvalid=0, all ready=0; with ports 1 and 3 valid, port 1 is granted first (rr_ptr=0).
//  6. Randomized valid/ready on all ports for 10k cycles ->
//     per-port frame contents preserved, no interleaving, every requesting port is served within S_COUNT frames.

Source files
------------

// File: rtl/axis_rr_frame_arb.sv
// Frame-aware round-robin AXI4-Stream arbiter: S_COUNT sources share one sink.
// A grant is held for a whole frame; the output stage is registered and tagged with the source index.
module axis_rr_frame_arb #(
    parameter int  S_COUNT    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  USER_WIDTH = 1,
    localparam int SEL_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [SEL_WIDTH-1:0]          m_axis_tid,
    output logic                          grant_valid,
    output logic [SEL_WIDTH-1:0]          grant_index
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SEL_WIDTH-1:0]   rr_ptr;
    logic [SEL_WIDTH-1:0]   grant_q;
    logic [SEL_WIDTH-1:0]   pick;

    logic                   out_ready;
    logic                   accept;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [USER_WIDTH-1:0]  sel_user;

    logic                   vld_p1;
    logic                   tlast_p1;
    logic [DATA_WIDTH-1:0]  tdata_p1;
    logic [USER_WIDTH-1:0]  tuser_p1;
    logic [SEL_WIDTH-1:0]   tid_p1;

    // First requesting port at or after ptr, scanning upward with wrap.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [S_COUNT-1:0] req,
                                                     input logic [SEL_WIDTH-1:0] ptr);
        logic [SEL_WIDTH-1:0] sel;
        int                   best;
        int                   off;
        sel  = ptr;
        best = S_COUNT;
        for (int i = 0; i < S_COUNT; i++) begin
            off = (i - int'(ptr) + S_COUNT) % S_COUNT;
            if (req[i] && (off < best)) begin
                best = off;
                sel  = SEL_WIDTH'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] next_port(input logic [SEL_WIDTH-1:0] p);
        if (p == SEL_WIDTH'(S_COUNT - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign pick = rr_pick(s_axis_tvalid, rr_ptr);

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == SEL_WIDTH'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // The output register may take a new beat when empty or being drained this cycle.
    assign out_ready = m_axis_tready | ~vld_p1;
    assign accept    = (state_q == ACTIVE) & out_ready & sel_valid & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && (|s_axis_tvalid)) begin
                grant_q <= pick;
            end
            if (accept && sel_last) begin
                rr_ptr <= next_port(grant_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        grant_valid   = (state_q == ACTIVE);
        if ((state_q == ACTIVE) && !rst) begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (grant_q == SEL_WIDTH'(i)) begin
                    s_axis_tready[i] = out_ready;
                end
            end
        end
    end

    // Stage p1: registered output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (out_ready) begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tdata_p1 <= sel_data;
            tlast_p1 <= sel_last;
            tuser_p1 <= sel_user;
            tid_p1   <= grant_q;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tlast  = tlast_p1;
    assign m_axis_tuser  = tuser_p1;
    assign m_axis_tid    = tid_p1;
    assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_rr_frame_arb.sv
// Directed and randomized bench for axis_rr_frame_arb with per-port scoreboard queues.
module tb_axis_rr_frame_arb;
    localparam int S  = 4;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [S*DW-1:0] s_tdata  = '0;
    logic [S-1:0]  s_tvalid = '0;
    logic [S-1:0]  s_tready;
    logic [S-1:0]  s_tlast  = '0;
    logic [S*UW-1:0] s_tuser = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [SW-1:0] m_tid;
    logic          grant_valid;
    logic [SW-1:0] grant_index;

    axis_rr_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tid(m_tid),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [UW-1:0] u;
        int            gap;
    } beat_t;

    beat_t           src_q [S][$];
    logic [DW+UW:0]  exp_q [S][$];
    logic [DW+UW:0]  mon_e;
    int errors = 0, checks = 0;
    int cyc = 0, out_beats = 0, frames_out = 0, frames_sent = 0, max_wait = 0;
    int fs_tid[$], fs_cyc[$];
    int wait_cnt [S];
    int gap_left [S];
    bit gap_armed [S];
    bit in_frame = 0;
    int cur_tid = 0;
    logic [S-1:0] acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input int p, input int len, input int gap_idx, input int gap_len,
                              input bit rnd, input int fixed_d);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d   = (fixed_d >= 0) ? DW'(fixed_d) : DW'($urandom);
            b.l   = (i == len - 1);
            b.u   = UW'($urandom);
            b.gap = rnd ? int'($urandom_range(0, 3)) : ((i == gap_idx) ? gap_len : 0);
            src_q[p].push_back(b);
            exp_q[p].push_back({b.d, b.l, b.u});
        end
        frames_sent++;
    endtask

    function automatic bit busy();
        bit b;
        b = m_tvalid || grant_valid || (s_tvalid != '0);
        for (int p = 0; p < S; p++) begin
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy()), 0);
        @(negedge clk);
    endtask

    // Source drivers and output monitor share one process so flushes and pops are ordered.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
            end else begin
                chk("ready_onehot0", 32'($onehot0(s_tready)), 1);
                if (m_tvalid && m_tready) begin
                    if (!in_frame) begin
                        fs_tid.push_back(int'(m_tid));
                        fs_cyc.push_back(cyc);
                        for (int p = 0; p < S; p++) begin
                            if (p != int'(m_tid) && s_tvalid[p]) begin
                                wait_cnt[p]++;
                                if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
                            end
                        end
                        wait_cnt[m_tid] = 0;
                        in_frame = 1;
                        cur_tid  = int'(m_tid);
                    end else begin
                        chk("no_interleave", 32'(m_tid), 32'(cur_tid));
                    end
                    if (exp_q[m_tid].size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        mon_e = exp_q[m_tid].pop_front();
                        chk("sb_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(mon_e));
                    end
                    out_beats++;
                    if (m_tlast) begin
                        frames_out++;
                        in_frame = 0;
                    end
                end
            end
            if (rst) begin
                acc = '0;
                for (int p = 0; p < S; p++) begin
                    src_q[p].delete();
                    exp_q[p].delete();
                    s_tvalid[p]  = 1'b0;
                    gap_armed[p] = 0;
                    wait_cnt[p]  = 0;
                end
            end else begin
                acc = s_tvalid & s_tready;
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < S; p++) begin
                if (acc[p]) begin
                    src_q[p].delete(0);
                    s_tvalid[p]  = 1'b0;
                    gap_armed[p] = 0;
                end
                if (!s_tvalid[p] && src_q[p].size() > 0) begin
                    if (!gap_armed[p]) begin
                        gap_left[p]  = src_q[p][0].gap;
                        gap_armed[p] = 1;
                    end
                    if (gap_left[p] == 0) begin
                        s_tvalid[p]         = 1'b1;
                        s_tdata[p*DW +: DW] = src_q[p][0].d;
                        s_tlast[p]          = src_q[p][0].l;
                        s_tuser[p*UW +: UW] = src_q[p][0].u;
                    end else begin
                        gap_left[p]--;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, n, leak, held_bad, ob0, fo0, fsn0;
        logic [31:0] snap;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tready", 32'(s_tready), 0);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_index", 32'(grant_index), 0);

        // All four ports request at once, port 0 with two frames
        base = fs_tid.size();
        for (int p = 0; p < S; p++) send_frame(p, 3, -1, 0, 0, -1);
        send_frame(0, 3, -1, 0, 0, -1);
        wait_idle("t1_drain", 200);
        chk("t1_frames", 32'(fs_tid.size() - base), 5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < fs_tid.size()) chk("t1_order", 32'(fs_tid[base+k]), 32'(k % 4));
        end
        for (int k = 1; k < 5; k++) begin
            if (base + k < fs_cyc.size())
                chk("t1_spacing", 32'(fs_cyc[base+k] - fs_cyc[base+k-1]), 4);
        end

        // Single-beat frame latency on port 2
        send_frame(2, 1, -1, 0, 0, 8'hA5);
        @(negedge clk);
        chk("t2_req_tvalid", 32'(s_tvalid), 32'b0100);
        chk("t2_idle_tready", 32'(s_tready), 0);
        chk("t2_idle_grant", 32'(grant_valid), 0);
        @(negedge clk);
        chk("t2_tready", 32'(s_tready), 32'b0100);
        chk("t2_grant_valid", 32'(grant_valid), 1);
        chk("t2_grant_index", 32'(grant_index), 2);
        @(negedge clk);
        chk("t2_out_tvalid", 32'(m_tvalid), 1);
        chk("t2_out_tdata", 32'(m_tdata), 32'hA5);
        chk("t2_out_tid", 32'(m_tid), 2);
        chk("t2_out_tlast", 32'(m_tlast), 1);
        chk("t2_grant_drop", 32'(grant_valid), 0);
        wait_idle("t2_drain", 50);

        // Granted port 1 stalls mid-frame while port 3 waits
        base = fs_tid.size();
        send_frame(1, 4, 2, 5, 0, -1);
        n = 0;
        while (!(grant_valid && grant_index == 1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_grant1", 32'(grant_valid && grant_index == 1), 1);
        send_frame(3, 2, -1, 0, 0, -1);
        leak = 0;
        held_bad = 0;
        n = 0;
        while (src_q[1].size() > 0 && n < 60) begin
            if (s_tready[3]) leak++;
            if (!(grant_valid && grant_index == 1)) held_bad++;
            @(negedge clk);
            n++;
        end
        chk("t3_port1_done", 32'(src_q[1].size()), 0);
        chk("t3_no_ready3", 32'(leak), 0);
        chk("t3_grant_held", 32'(held_bad), 0);
        wait_idle("t3_drain", 100);
        chk("t3_frames", 32'(fs_tid.size() - base), 2);
        if (fs_tid.size() >= base + 2) begin
            chk("t3_first", 32'(fs_tid[base]), 1);
            chk("t3_second", 32'(fs_tid[base+1]), 3);
        end

        // Downstream stall mid-frame
        ob0 = out_beats;
        send_frame(0, 6, -1, 0, 0, -1);
        n = 0;
        while (out_beats < ob0 + 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t4_started", 32'(out_beats >= ob0 + 2), 1);
        @(posedge clk);
        #1 m_tready = 1'b0;
        snap = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_stall_tvalid", 32'(m_tvalid), 1);
            chk("t4_stall_tready", 32'(s_tready), 0);
            if (k == 0) snap = 32'({m_tdata, m_tlast, m_tid});
            else chk("t4_stall_hold", 32'({m_tdata, m_tlast, m_tid}), snap);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_idle("t4_drain", 100);
        chk("t4_beats", 32'(out_beats - ob0), 6);

        // Reset during the second beat of a port-3 frame
        send_frame(3, 4, -1, 0, 0, -1);
        n = 0;
        while (!(s_tvalid[3] && s_tready[3]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_start", 32'(s_tvalid[3] && s_tready[3]), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_tvalid", 32'(m_tvalid), 0);
        chk("t5_tready", 32'(s_tready), 0);
        chk("t5_grant_valid", 32'(grant_valid), 0);
        send_frame(1, 2, -1, 0, 0, -1);
        send_frame(3, 2, -1, 0, 0, -1);
        n = 0;
        while (!grant_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_grant_valid2", 32'(grant_valid), 1);
        chk("t5_grant_port1", 32'(grant_index), 1);
        wait_idle("t5_drain", 100);

        // Randomized traffic and backpressure
        fo0  = frames_out;
        fsn0 = frames_sent;
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1 m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int p = 0; p < S; p++) begin
                if (src_q[p].size() < 4 && $urandom_range(0, 7) == 0)
                    send_frame(p, int'($urandom_range(1, 5)), -1, 0, 1, -1);
            end
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_idle("t6_drain", 3000);
        chk("t6_frames", 32'(frames_out - fo0), 32'(frames_sent - fsn0));
        chk("t6_fairness", 32'(max_wait <= S), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
